mmio_data_memory: RTL

- Slave side of the DataMemoryWithMMIO port: the block the core's load/store stage talks to.
- Decodes each access to one of two targets: an internal word-addressed data BRAM, or a small MMIO window fronting the UART.
- Contains a UART RX byte FIFO and a 4-byte word assembler for program/data loading.
- Drives stall whenever an access cannot complete in its issue cycle.

---
 rtl/mmio_data_memory.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : mmio_data_memory
// Purpose  : Load/store slave for the core. Decodes each access to a
//            word-addressed data BRAM or to a small MMIO window fronting the
//            UART. Holds an RX byte FIFO and a 4-byte little-endian word
//            assembler used for program/data loading.
// Ports    : clk, nrst               - clock, async active-low reset
//            en, we, addr, wd        - access request (held while stall=1)
//            stall                   - access not completed this cycle (comb.)
//            rd                      - load data, valid the cycle after completion
//            rd_inst                 - last assembled RX word
//            uart_rx_valid/_data     - received byte strobe and value
//            uart_tx_ready           - transmitter can take a byte
//            uart_tx_valid/_data     - one-cycle byte-to-send strobe and value
// Revision : 1.0 - initial release
// ============================================================================
module mmio_data_memory #(
  parameter int          DMEM_ADDR_W = 15,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          RX_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        stall,
  output logic [31:0] rd,
  output logic [31:0] rd_inst,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_tx_ready,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RX_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  localparam logic [1:0] OFF_RX_BYTE = 2'd0;
  localparam logic [1:0] OFF_TX_BYTE = 2'd1;
  localparam logic [1:0] OFF_RX_WORD = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ASM_IDLE    = 2'd0,
    ASM_COLLECT = 2'd1,
    ASM_DONE    = 2'd2
  } asm_state_t;

  // ---------------------------------------------------------------- decode
  logic                   is_mmio;
  logic [1:0]             mmio_off;
  logic [DMEM_ADDR_W-1:0] word_idx;
  logic                   rx_byte_ld, tx_byte_st, rx_word_ld, status_st;

  assign is_mmio    = (addr >= MMIO_BASE);
  assign mmio_off   = addr[3:2];
  assign word_idx   = addr[DMEM_ADDR_W+1:2];
  assign rx_byte_ld = en & ~we & is_mmio & (mmio_off == OFF_RX_BYTE);
  assign tx_byte_st = en &  we & is_mmio & (mmio_off == OFF_TX_BYTE);
  assign rx_word_ld = en & ~we & is_mmio & (mmio_off == OFF_RX_WORD);
  assign status_st  = en &  we & is_mmio & (mmio_off == OFF_STATUS);

  // ------------------------------------------------------- stall/complete
  asm_state_t asm_state;
  logic       fifo_nonempty;
  logic       stall_req, done, load_done, store_done;

  always_comb begin
    stall_req = 1'b0;
    if (rx_byte_ld)      stall_req = ~fifo_nonempty;
    else if (tx_byte_st) stall_req = ~uart_tx_ready;
    else if (rx_word_ld) stall_req = (asm_state != ASM_DONE);
  end

  // Gating with nrst keeps stall low and suppresses side effects in reset.
  assign stall      = nrst & stall_req;
  assign done       = nrst & en & ~stall_req;
  assign load_done  = done & ~we;
  assign store_done = done & we;

  // --------------------------------------------------------------- RX FIFO
  logic [7:0]       fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             overflow;
  logic             fifo_full, fifo_push, fifo_pop, collect_pop;
  logic [7:0]       fifo_head;

  assign fifo_nonempty = (fifo_cnt != '0);
  assign fifo_full     = (fifo_cnt == FIFO_FULL);
  assign fifo_head     = fifo_mem[rd_ptr];
  // The assembler pops while the access is still stalled.
  assign collect_pop   = nrst & rx_word_ld & (asm_state == ASM_COLLECT) & fifo_nonempty;
  assign fifo_pop      = (load_done & rx_byte_ld) | collect_pop;
  // A pop in the same cycle frees the slot the push needs.
  assign fifo_push     = uart_rx_valid & (~fifo_full | fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= uart_rx_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
      // Set takes priority over a same-cycle clear so no drop goes unseen.
      if (uart_rx_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (store_done && status_st && wd[2])   overflow <= 1'b0;
    end
  end

  // ------------------------------------------------------------------ BRAM
  logic [31:0] bram [2**DMEM_ADDR_W];
  logic [31:0] bram_q;

  // Read port only enabled on a completed load so bram_q holds between loads.
  always_ff @(posedge clk) begin
    if (store_done && !is_mmio) bram[word_idx] <= wd;
    if (load_done && !is_mmio)  bram_q <= bram[word_idx];
  end

  // -------------------------------------------------------- word assembler
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      asm_state <= ASM_IDLE;
      byte_cnt  <= 2'd0;
      asm_word  <= '0;
      rd_inst   <= '0;
    end else begin
      case (asm_state)
        ASM_IDLE: begin
          if (rx_word_ld) begin
            asm_state <= ASM_COLLECT;
            byte_cnt  <= 2'd0;
            asm_word  <= '0;
          end
        end
        ASM_COLLECT: begin
          if (collect_pop) begin
            asm_word[{byte_cnt, 3'b000} +: 8] <= fifo_head;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) asm_state <= ASM_DONE;
          end
        end
        ASM_DONE: begin
          if (load_done && rx_word_ld) begin
            rd_inst   <= asm_word;
            asm_state <= ASM_IDLE;
          end
        end
        default: asm_state <= ASM_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------ read data / TX
  logic        rd_sel_bram;
  logic [31:0] rd_mmio;
  logic [31:0] status_word;

  assign status_word = {29'b0, overflow, uart_tx_ready, fifo_nonempty};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_sel_bram   <= 1'b0;
      rd_mmio       <= '0;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      uart_tx_valid <= 1'b0;
      if (store_done && tx_byte_st) begin
        uart_tx_valid <= 1'b1;
        uart_tx_data  <= wd[7:0];
      end
      if (load_done) begin
        rd_sel_bram <= ~is_mmio;
        case (mmio_off)
          OFF_RX_BYTE: rd_mmio <= {24'b0, fifo_head};
          OFF_TX_BYTE: rd_mmio <= '0;
          OFF_RX_WORD: rd_mmio <= asm_word;
          default:     rd_mmio <= status_word;
        endcase
      end
    end
  end

  // BRAM data comes straight from its output register; MMIO data from rd_mmio.
  assign rd = rd_sel_bram ? bram_q : rd_mmio;

endmodule
`default_nettype wire
